// File: rtl/prog_loader_pkg.sv
// Shared types and sizing for the UART program loader.
package prog_loader_pkg;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BCNT_W         = 2;
    localparam int unsigned IDX_W          = 15;
    localparam int unsigned ADR_W          = 14;
    localparam int unsigned DAT_W          = 32;
    localparam int unsigned LEN_W          = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    typedef struct packed {
        logic             wen;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } rom_wr_t;

endpackage

// File: rtl/prog_loader_if.sv
// Received-byte stream handshake into the loader.
interface prog_loader_if
    import prog_loader_pkg::*;
();
    logic              rx_valid;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_ready;

    modport master (output rx_valid, output rx_data, input rx_ready);
    modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear.
module loader_timeout #(
    parameter int unsigned LIMIT = 32'd10_000_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_c
);
    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the idle cycle that would make the count reach LIMIT.
    assign expired_c = en_i && !clr_i && (cnt_q == CW'(LIMIT - 1));
endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed little-endian program from a byte stream into the CPU ROM.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd10_000_000,
    parameter int unsigned MAX_WORDS      = 16384
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    prog_loader_if.slave      rx,
    output logic              upg_rst_o,
    output logic              upg_wen_o,
    output logic [ADR_W-1:0]  upg_adr_o,
    output logic [DAT_W-1:0]  upg_dat_o,
    output logic              upg_done_o,
    output logic              err_o
);
    state_e              state_q, state_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [LEN_W-1:0]    n_q, n_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    rom_wr_t             wr_q, wr_d;
    logic                rx_ready_q, upg_rst_q, done_q, err_q;

    logic                accept;
    logic                loading;
    logic                to_expired;
    logic [LEN_W-1:0]    n_full;
    logic [IDX_W-1:0]    idx_inc;

    assign accept  = rx.rx_valid && rx_ready_q;
    assign loading = (state_q == ST_HDR) || (state_q == ST_DATA);
    assign n_full  = {rx.rx_data, n_q[BYTE_W-1:0]};
    assign idx_inc = idx_q + IDX_W'(1);

    loader_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk       (clk),
        .rstn      (rstn),
        .clr_i     (!loading || accept || start),
        .en_i      (loading),
        .expired_c (to_expired)
    );

    // Next-state and datapath; start overrides everything, including a same-cycle byte.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        n_d     = n_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        if (start) begin
            state_d = ST_HDR;
            bcnt_d  = '0;
            n_d     = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_HDR: begin
                    if (to_expired) begin
                        state_d = ST_ERR;
                    end else if (accept) begin
                        if (bcnt_q == BCNT_W'(HDR_BYTES - 1)) begin
                            bcnt_d = '0;
                            n_d    = n_full;
                            if (n_full == '0) begin
                                state_d = ST_DONE;
                            end else if (32'(n_full) > MAX_WORDS) begin
                                state_d = ST_ERR;
                            end else begin
                                state_d = ST_DATA;
                            end
                        end else begin
                            n_d[BYTE_W-1:0] = rx.rx_data;
                            bcnt_d          = bcnt_q + BCNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (to_expired) begin
                        state_d = ST_ERR;
                    end else if (accept) begin
                        wr_d.dat[{bcnt_q, 3'b000} +: BYTE_W] = rx.rx_data;
                        if (bcnt_q == BCNT_W'(BYTES_PER_WORD - 1)) begin
                            bcnt_d   = '0;
                            wr_d.adr = idx_q[ADR_W-1:0];
                            state_d  = ST_WRITE;
                        end else begin
                            bcnt_d = bcnt_q + BCNT_W'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    idx_d   = idx_inc;
                    state_d = (LEN_W'(idx_inc) == n_q) ? ST_DONE : ST_DATA;
                end
                ST_IDLE, ST_DONE, ST_ERR: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        wr_d.wen = (state_d == ST_WRITE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            bcnt_q     <= '0;
            n_q        <= '0;
            idx_q      <= '0;
            wr_q       <= '0;
            rx_ready_q <= 1'b0;
            upg_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            wr_q       <= wr_d;
            rx_ready_q <= (state_d == ST_HDR) || (state_d == ST_DATA);
            upg_rst_q  <= !((state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_WRITE));
            done_q     <= (state_d == ST_DONE);
            err_q      <= (state_d == ST_ERR);
        end
    end

    assign rx.rx_ready = rx_ready_q;
    assign upg_rst_o   = upg_rst_q;
    assign upg_wen_o   = wr_q.wen;
    assign upg_adr_o   = wr_q.adr;
    assign upg_dat_o   = wr_q.dat;
    assign upg_done_o  = done_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed table-driven bench for prog_loader plus hand sequences for timeout, restart and reset.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        upg_rst_o, upg_wen_o, upg_done_o, err_o;
    logic [13:0] upg_adr_o;
    logic [31:0] upg_dat_o;

    prog_loader_if rxif ();

    prog_loader #(.TIMEOUT_CYCLES(100), .MAX_WORDS(16384)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .rx         (rxif),
        .upg_rst_o  (upg_rst_o),
        .upg_wen_o  (upg_wen_o),
        .upg_adr_o  (upg_adr_o),
        .upg_dat_o  (upg_dat_o),
        .upg_done_o (upg_done_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0][7:0] b;
        logic [4:0]       nb;
        logic [1:0]       nw;
        logic [2:0][31:0] dat;
        logic             done;
        logic             err;
        logic [1:0]       stalls;
    } vec_t;

    vec_t        vecs [5];
    logic [45:0] wq [$];
    int          n_pass = 0;
    int          n_total = 0;
    int          viol = 0;

    always @(negedge clk) begin
        if (upg_wen_o) wq.push_back({upg_adr_o, upg_dat_o});
        if (upg_wen_o && upg_rst_o) viol++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called on a falling edge; returns on the falling edge after start was sampled.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Streams n bytes back to back with rx_valid held, counting cycles refused by the DUT.
    task automatic send_seq(input logic [13:0][7:0] b, input int n, output int stalls);
        int guard;
        stalls = 0;
        for (int k = 0; k < n; k++) begin
            rxif.rx_valid = 1'b1;
            rxif.rx_data  = b[k];
            guard = 0;
            while (!rxif.rx_ready && guard < 20) begin
                stalls++;
                guard++;
                @(negedge clk);
            end
            if (guard >= 20) begin
                chk("rx_ready wait", 32'd0, 32'd1);
                break;
            end
            @(negedge clk);
        end
        rxif.rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit");
        $fatal(1);
    end

    initial begin
        int st;
        int n;

        vecs[0] = '{b: 112'({8'hDE,8'hAD,8'hBE,8'hEF,8'h12,8'h34,8'h56,8'h78,8'h00,8'h02}),
                    nb: 5'd10, nw: 2'd2, dat: 96'({32'hDEADBEEF, 32'h12345678}),
                    done: 1'b1, err: 1'b0, stalls: 2'd1};
        vecs[1] = '{b: 112'({8'h00,8'h00}), nb: 5'd2, nw: 2'd0, dat: '0,
                    done: 1'b1, err: 1'b0, stalls: 2'd0};
        vecs[2] = '{b: 112'({8'h40,8'h01}), nb: 5'd2, nw: 2'd0, dat: '0,
                    done: 1'b0, err: 1'b1, stalls: 2'd0};
        vecs[3] = '{b: 112'({8'hA5,8'hC3,8'h0F,8'h1E,8'h00,8'h01}), nb: 5'd6, nw: 2'd1,
                    dat: 96'(32'hA5C30F1E), done: 1'b1, err: 1'b0, stalls: 2'd0};
        vecs[4] = '{b: 112'({8'h80,8'h00,8'h00,8'h01,8'hFF,8'hFF,8'hFF,8'hFF,
                             8'h00,8'h00,8'h00,8'h00,8'h00,8'h03}),
                    nb: 5'd14, nw: 2'd3, dat: {32'h80000001, 32'hFFFFFFFF, 32'h00000000},
                    done: 1'b1, err: 1'b0, stalls: 2'd2};

        rstn = 1'b0;
        start = 1'b0;
        rxif.rx_valid = 1'b0;
        rxif.rx_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset upg_rst", 32'(upg_rst_o), 32'd1);
        chk("reset done", 32'(upg_done_o), 32'd0);
        chk("reset err", 32'(err_o), 32'd0);
        chk("reset wen", 32'(upg_wen_o), 32'd0);
        chk("reset adr", 32'(upg_adr_o), 32'd0);
        chk("reset dat", upg_dat_o, 32'd0);
        chk("reset rx_ready", 32'(rxif.rx_ready), 32'd0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("post-reset cpu mode", 32'(upg_rst_o), 32'd1);
        chk("post-reset idle ready", 32'(rxif.rx_ready), 32'd0);

        for (int i = 0; i < 5; i++) begin
            wq.delete();
            pulse_start();
            chk($sformatf("v%0d start upg_rst", i), 32'(upg_rst_o), 32'd0);
            chk($sformatf("v%0d start done", i), 32'(upg_done_o), 32'd0);
            chk($sformatf("v%0d start err", i), 32'(err_o), 32'd0);
            chk($sformatf("v%0d start rx_ready", i), 32'(rxif.rx_ready), 32'd1);
            send_seq(vecs[i].b, int'(vecs[i].nb), st);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d write count", i), 32'(wq.size()), 32'(vecs[i].nw));
            for (int w = 0; w < int'(vecs[i].nw); w++) begin
                if (w < wq.size()) begin
                    chk($sformatf("v%0d w%0d adr", i, w), 32'(wq[w][45:32]), 32'(w));
                    chk($sformatf("v%0d w%0d dat", i, w), wq[w][31:0], vecs[i].dat[w]);
                end
            end
            chk($sformatf("v%0d done", i), 32'(upg_done_o), 32'(vecs[i].done));
            chk($sformatf("v%0d err", i), 32'(err_o), 32'(vecs[i].err));
            chk($sformatf("v%0d upg_rst", i), 32'(upg_rst_o), 32'd1);
            chk($sformatf("v%0d rx_ready", i), 32'(rxif.rx_ready), 32'd0);
            chk($sformatf("v%0d stall cycles", i), 32'(st), 32'(vecs[i].stalls));
        end

        // Empty program: done straight after the second header byte.
        wq.delete();
        pulse_start();
        send_seq(112'({8'h00, 8'h00}), 2, st);
        chk("hdr0 done prompt", 32'(upg_done_o), 32'd1);
        @(negedge clk);
        chk("hdr0 no write", 32'(wq.size()), 32'd0);

        // N equal to ROM depth is legal.
        pulse_start();
        send_seq(112'({8'h40, 8'h00}), 2, st);
        chk("nmax err", 32'(err_o), 32'd0);
        chk("nmax in data", 32'(rxif.rx_ready), 32'd1);

        // Stall mid-word: error exactly TIMEOUT_CYCLES after the last byte, nothing written.
        wq.delete();
        pulse_start();
        send_seq(112'({8'hBB, 8'hAA, 8'h00, 8'h02}), 4, st);
        n = 0;
        while (!err_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("timeout cycles", 32'(n), 32'd100);
        chk("timeout no write", 32'(wq.size()), 32'd0);
        chk("timeout upg_rst", 32'(upg_rst_o), 32'd1);

        // Restart mid-load; the byte offered with start must be dropped.
        wq.delete();
        pulse_start();
        send_seq(112'({8'h44, 8'h33, 8'h22, 8'h11, 8'h00, 8'h03}), 6, st);
        repeat (2) @(negedge clk);
        chk("restart first write", 32'(wq.size()), 32'd1);
        start = 1'b1;
        rxif.rx_valid = 1'b1;
        rxif.rx_data = 8'h99;
        @(negedge clk);
        start = 1'b0;
        rxif.rx_valid = 1'b0;
        chk("restart in hdr", 32'(rxif.rx_ready), 32'd1);
        send_seq(112'({8'h88, 8'h77, 8'h66, 8'h55, 8'h00, 8'h01}), 6, st);
        repeat (3) @(negedge clk);
        chk("restart write count", 32'(wq.size()), 32'd2);
        if (wq.size() >= 2) begin
            chk("restart adr", 32'(wq[1][45:32]), 32'd0);
            chk("restart dat", wq[1][31:0], 32'h88776655);
        end
        chk("restart done", 32'(upg_done_o), 32'd1);

        // Asynchronous reset while a partly assembled second word is pending.
        pulse_start();
        send_seq(112'({8'hC1, 8'hB4, 8'hB3, 8'hB2, 8'hB1, 8'hA4, 8'hA3, 8'hA2, 8'hA1,
                       8'h00, 8'h03}), 11, st);
        chk("pre-reset adr", 32'(upg_adr_o), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("async upg_rst", 32'(upg_rst_o), 32'd1);
        chk("async rx_ready", 32'(rxif.rx_ready), 32'd0);
        chk("async adr", 32'(upg_adr_o), 32'd0);
        chk("async dat", upg_dat_o, 32'd0);
        chk("async wen", 32'(upg_wen_o), 32'd0);
        chk("async done", 32'(upg_done_o), 32'd0);
        chk("async err", 32'(err_o), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        chk("after reset cpu mode", 32'(upg_rst_o), 32'd1);
        chk("after reset idle", 32'(rxif.rx_ready), 32'd0);

        chk("wen under upg_rst", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 32'd10_000_000, giving the maximum idle cycles between accepted bytes while loading.
REQ-002 The block SHALL have parameter MAX_WORDS, default 16384, giving the program ROM depth in 32-bit words.
REQ-003 The block SHALL have port clk, input, 1, the system clock; upg_* outputs are synchronous to it.
REQ-004 The block SHALL have port rstn, input, 1, reset: asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1, a one-cycle pulse requesting a new program upload.
REQ-006 The block SHALL have ports rx_valid, input, 1, and rx_data, input, 8, the received UART byte stream.
REQ-007 The block SHALL have port rx_ready, output, 1; a byte transfers on a cycle where rx_valid and rx_ready are both high.
REQ-008 The block SHALL have port upg_rst_o, output, 1; high means the CPU owns the ROM, low means the loader owns it.
REQ-009 The block SHALL have ports upg_wen_o (output, 1), upg_adr_o (output, 14) and upg_dat_o (output, 32), the ROM write port.
REQ-010 The block SHALL have port upg_done_o, output, 1; it is high after a successful load until the next start.
REQ-011 The block SHALL have port err_o, output, 1; it is high after a timeout or bad header until the next start.

Function
REQ-012 The FSM SHALL have states IDLE, HDR, DATA, WRITE, DONE and ERR.
REQ-013 In IDLE, on start the FSM SHALL go to HDR, drive upg_rst_o=0, and clear upg_done_o, err_o, the byte counter and the word index.
REQ-014 HDR SHALL accept 2 bytes forming word count N, little-endian (first byte = N[7:0]).
REQ-015 After the second header byte: N=0 SHALL go to DONE; N>MAX_WORDS SHALL go to ERR; otherwise the FSM SHALL go to DATA.
REQ-016 DATA SHALL accept 4 bytes per word, little-endian: byte k fills upg_dat_o[8k+7:8k].
REQ-017 The cycle after the 4th byte is accepted, the FSM SHALL be in WRITE for exactly one cycle, with upg_wen_o=1, upg_adr_o=word index, and upg_dat_o=the assembled word.
REQ-018 rx_ready SHALL be 1 only in HDR and DATA, and 0 in IDLE, WRITE, DONE and ERR; no byte is dropped during WRITE.
REQ-019 After WRITE, the word index SHALL increment; if it reaches N the FSM goes to DONE, else it returns to DATA.
REQ-020 The word index SHALL be 15 bits internally; upg_adr_o SHALL be its low 14 bits, and the index never exceeds MAX_WORDS.
REQ-021 DONE SHALL drive upg_done_o=1 and upg_rst_o=1, and hold until the next start.
REQ-022 ERR SHALL drive err_o=1, upg_rst_o=1 and upg_done_o=0, and hold until the next start.
REQ-023 In HDR and DATA, the timeout counter SHALL clear on each accepted byte and increment otherwise; reaching TIMEOUT_CYCLES SHALL go to ERR.
REQ-024 A start pulse in any state, including mid-load, SHALL restart in HDR; words already written are not rolled back.
REQ-025 If start and an rx handshake occur in the same cycle, start SHALL win and the byte is discarded.
REQ-026 upg_wen_o SHALL never be high while upg_rst_o=1.

Reset
REQ-027 Reset SHALL force state IDLE, upg_rst_o=1, upg_done_o=0, err_o=0, upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, rx_ready=0, and clear all counters.
REQ-028 Reset deassertion SHALL require no start pulse for the CPU to run: the ROM stays in CPU mode.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (3 bits), the header length (2) and the bytes-per-word (4).
REQ-030 One sub-module, loader_timeout (counter with clear, enable and expiry flag), SHALL implement REQ-023; all else is flat.

Verification
REQ-031 Load 2 words: start, bytes 02 00 | 78 56 34 12 | EF BE AD DE -> writes (0,0x12345678) then (1,0xDEADBEEF), then upg_done_o=1 and upg_rst_o=1.
REQ-032 Header 00 00 -> no upg_wen_o pulse, upg_done_o=1 within 2 cycles of the 2nd header byte.
REQ-033 Header 01 40 (N=16385) -> err_o=1, no writes; with TIMEOUT_CYCLES=100, a stall after 2 data bytes -> err_o=1 at cycle 100, no write.
REQ-034 rx_valid held high continuously -> rx_ready drops for exactly the WRITE cycle and all 8 data bytes land correctly.
REQ-035 start asserted after word 0 of N=3 -> restart in HDR, new header accepted, word index restarts at 0; start on the same cycle as a byte -> byte discarded.
REQ-036 rstn pulse low mid-DATA -> all outputs take their REQ-027 values immediately, asynchronously.
